uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_tx.sv | 120 ++++++++++++
 tb/tb_uart_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default line parameters,
// used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over counting so every state entry starts a fresh period.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, one stop
// bit. The serial line is driven straight from a flop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 TX_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q;
    uart_state_e          state_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [IDX_W-1:0]     bit_idx_d;
    logic                 parity_q;
    logic                 parity_d;
    logic                 tx_out_q;
    logic                 tx_out_d;
    logic                 accept;
    logic                 baud_clear;
    logic                 baud_en;
    logic                 bit_end;

    assign accept     = tx_valid && (state_q == IDLE);
    assign baud_clear = (state_d != state_q);
    assign baud_en    = (state_q != IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (baud_clear),
        .enable  (baud_en),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && (bit_idx_q == LAST_IDX)) state_d = PARITY_EN ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Index idles at zero outside DATA, so it is already clear on DATA entry.
    always_comb begin
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        if (accept) begin
            shift_d  = tx_data;
            parity_d = ^tx_data;
        end
        if (state_q != DATA) begin
            bit_idx_d = '0;
        end else if (bit_end) begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            tx_out_q  <= 1'b1;
        end else begin
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            tx_out_q  <= tx_out_d;
        end
    end

    // Line level is computed from the upcoming state so the flop holds the
    // current bit for the whole period.
    always_comb begin
        tx_out_d = 1'b1;
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
            PARITY:  tx_out_d = parity_d;
            default: tx_out_d = 1'b1;
        endcase
        tx_ready = (state_q == IDLE);
        tx_busy  = (state_q != IDLE);
        tx_done  = (state_q == STOP) && bit_end;
    end

    assign TX_out = tx_out_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three parameterisations, frames compared
// against a bit-period model of the serial line.
module tb_uart_tx;

    logic       clk;
    logic [2:0] rst_n;
    logic [2:0] valid;
    logic [7:0] data [3];
    logic [2:0] ready;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] done;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1'b0)) u_dut_a (
        .clk(clk), .rst_n(rst_n[0]), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .TX_out(tx[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );

    uart_tx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n[1]), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .TX_out(tx[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );

    uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_EN(1'b0)) u_dut_c (
        .clk(clk), .rst_n(rst_n[2]), .tx_data(data[2][4:0]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .TX_out(tx[2]), .tx_busy(busy[2]), .tx_done(done[2])
    );

    // Expected line level k cycles after acceptance (k=1 is the first start cycle).
    function automatic logic exp_level(input logic [7:0] d, input int nbits,
                                       input int par, input int cpb, input int k);
        int   b;
        logic p;
        b = (k - 1) / cpb;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ d[i];
        if (b == 0) return 1'b0;
        if (b <= nbits) return d[b-1];
        if (par != 0 && b == nbits + 1) return p;
        return 1'b1;
    endfunction

    task automatic start_frame(input int s, input logic [7:0] d, input bit hold);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (ready[s] === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout dut%0d: tx_ready got %b expected 1", s, ready[s]);
        end
        data[s]  = d;
        valid[s] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) valid[s] = 1'b0;
    endtask

    task automatic capture_frame(input int s, input logic [7:0] d, input int nbits,
                                 input int par, input int cpb, input bit disturb,
                                 input string name);
        int           len;
        int           ndone;
        int           done_at;
        bit           busy_ok;
        logic [255:0] got;
        logic [255:0] expv;
        len     = (2 + nbits + par) * cpb;
        ndone   = 0;
        done_at = 0;
        busy_ok = 1'b1;
        got     = '0;
        expv    = '0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            got[k-1]  = tx[s];
            expv[k-1] = exp_level(d, nbits, par, cpb, k);
            if (done[s] === 1'b1) begin
                ndone++;
                done_at = k;
            end
            if (busy[s] !== 1'b1 || ready[s] !== 1'b0) busy_ok = 1'b0;
            if (disturb) begin
                data[s]  = 8'($urandom);
                valid[s] = (k < len) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s line: got %h expected %h", name, got, expv);
        end
        checks++;
        if (ndone !== 1 || done_at !== len) begin
            errors++;
            $display("[TB] FAIL %s done: got %0d pulses last at %0d expected 1 at %0d",
                     name, ndone, done_at, len);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("[TB] FAIL %s busy: got busy/ready wrong in frame expected busy=1 ready=0", name);
        end
    endtask

    task automatic check_idle(input int s, input string name);
        @(negedge clk);
        checks++;
        if (tx[s] !== 1'b1 || ready[s] !== 1'b1 || busy[s] !== 1'b0 || done[s] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s idle: got tx=%b ready=%b busy=%b done=%b expected 1 1 0 0",
                     name, tx[s], ready[s], busy[s], done[s]);
        end
    endtask

    task automatic test_reset();
        rst_n = 3'b000;
        valid = 3'b000;
        for (int i = 0; i < 3; i++) data[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx[i] !== 1'b1 || ready[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset dut%0d: got tx=%b ready=%b busy=%b done=%b expected 1 1 0 0",
                         i, tx[i], ready[i], busy[i], done[i]);
            end
        end
        rst_n = 3'b111;
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        start_frame(0, 8'hA5, 1'b0);
        capture_frame(0, 8'hA5, 8, 0, 16, 1'b0, "single_a5");
        check_idle(0, "single_a5");
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            start_frame(0, d, 1'b0);
            capture_frame(0, d, 8, 0, 16, 1'b0, "single_rand");
            check_idle(0, "single_rand");
        end
    endtask

    task automatic test_back_to_back();
        start_frame(0, 8'h00, 1'b1);
        capture_frame(0, 8'h00, 8, 0, 16, 1'b0, "b2b_first");
        check_idle(0, "b2b_gap");
        data[0] = 8'hFF;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        capture_frame(0, 8'hFF, 8, 0, 16, 1'b0, "b2b_second");
        check_idle(0, "b2b_end");
    endtask

    task automatic test_parity();
        logic [7:0] d;
        start_frame(1, 8'h07, 1'b0);
        capture_frame(1, 8'h07, 8, 1, 16, 1'b0, "parity_07");
        check_idle(1, "parity_07");
        start_frame(1, 8'h03, 1'b0);
        capture_frame(1, 8'h03, 8, 1, 16, 1'b0, "parity_03");
        check_idle(1, "parity_03");
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            start_frame(1, d, 1'b0);
            capture_frame(1, d, 8, 1, 16, 1'b0, "parity_rand");
            check_idle(1, "parity_rand");
        end
    endtask

    task automatic test_stability();
        bit quiet;
        start_frame(0, 8'h3C, 1'b0);
        capture_frame(0, 8'h3C, 8, 0, 16, 1'b1, "stable_3c");
        check_idle(0, "stable_3c");
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (busy[0] !== 1'b0 || tx[0] !== 1'b1 || done[0] !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("[TB] FAIL stable_extra_frame: got activity after frame expected quiet line");
        end
    endtask

    task automatic test_reset_mid_frame();
        bit no_done;
        start_frame(0, 8'hA5, 1'b0);
        repeat (68) @(negedge clk);
        checks++;
        if (tx[0] !== exp_level(8'hA5, 8, 0, 16, 68)) begin
            errors++;
            $display("[TB] FAIL rst_mid_bit3: got %b expected %b", tx[0], exp_level(8'hA5, 8, 0, 16, 68));
        end
        rst_n[0] = 1'b0;
        #1;
        checks++;
        if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_async: got tx=%b ready=%b busy=%b done=%b expected 1 1 0 0",
                     tx[0], ready[0], busy[0], done[0]);
        end
        no_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done[0] !== 1'b0) no_done = 1'b0;
        end
        rst_n[0] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) no_done = 1'b0;
        end
        checks++;
        if (!no_done) begin
            errors++;
            $display("[TB] FAIL rst_mid_no_done: got done/busy after abort expected none");
        end
        start_frame(0, 8'h5A, 1'b0);
        capture_frame(0, 8'h5A, 8, 0, 16, 1'b0, "rst_mid_5a");
        check_idle(0, "rst_mid_5a");
    endtask

    task automatic test_min_rate();
        logic [7:0] d;
        start_frame(2, 8'h15, 1'b0);
        capture_frame(2, 8'h15, 5, 0, 2, 1'b0, "min_rate_15");
        check_idle(2, "min_rate_15");
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 31));
            start_frame(2, d, 1'b0);
            capture_frame(2, d, 5, 0, 2, 1'b0, "min_rate_rand");
            check_idle(2, "min_rate_rand");
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_parity();
        test_stability();
        test_reset_mid_frame();
        test_min_rate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
